// File: rtl/shiftadd_mult_ctrl.sv
// shiftadd_mult_ctrl: sequences a shift-and-add multiplier datapath (load, test LSB, add, shift) with a done/ack handshake.
module shiftadd_mult_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          mul_lsb,
    input  logic          ack,
    output logic          load,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter_left
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ADD, SHIFT, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_q, add_q, shift_q, busy_q, done_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE:  state_d = start ? LOAD : IDLE;
                LOAD: begin
                    state_d = CHECK;
                    cnt_d   = CW'(WIDTH);
                end
                CHECK: state_d = mul_lsb ? ADD : SHIFT;
                ADD:   state_d = SHIFT;
                // Exit on the last iteration so the counter never wraps below zero
                SHIFT: begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = (cnt_q == CW'(1)) ? DONE : CHECK;
                end
                DONE: begin
                    cnt_d   = '0;
                    state_d = ack ? IDLE : DONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end
    // Outputs are registered from the next state, so they always mirror state_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            add_q   <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= state_d == LOAD;
            add_q   <= state_d == ADD;
            shift_q <= state_d == SHIFT;
            busy_q  <= state_d inside {LOAD, CHECK, ADD, SHIFT};
            done_q  <= state_d == DONE;
        end
    end
    assign load      = load_q;
    assign add_en    = add_q;
    assign shift_en  = shift_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign iter_left = cnt_q;
endmodule

// File: doc/shiftadd_mult_ctrl.md
Name: shiftadd_mult_ctrl

Overview:
- Control unit that sequences a shift-and-add multiplier datapath: product accumulator, multiplicand register and shifting multiplier register.
- Accepts a start request, loads the operands, then iterates WIDTH times. Each iteration tests the multiplier LSB, conditionally adds, then shifts.
- Signals completion with a done/ack handshake. Sits between the top-level input logic (operand-ready source) and the datapath; it contains no arithmetic.

Parameters:
- WIDTH, 8, operand width in bits = number of iterations (legal range 2..32).
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiplication; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE from any state
- mul_lsb  input  1  LSB of datapath multiplier register; valid in CHECK
- ack  input  1  consumer has taken the result; sampled only in DONE
- load  output  1  datapath: load operands, clear accumulator
- add_en  output  1  datapath: accumulator += multiplicand
- shift_en  output  1  datapath: shift multiplier right, multiplicand left
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  result valid; high for the whole DONE state
- iter_left  output  CW  iterations remaining (debug/observability)

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0; load=add_en=shift_en=busy=done=0; iter_left=0.
- Outputs are Moore, decoded from the state register only. There is no combinational path from any input to any output.
- States: IDLE, LOAD, CHECK, ADD, SHIFT, DONE.
- IDLE: all outputs 0. start=1 -> LOAD; otherwise stay.
- LOAD: load=1, busy=1 for exactly one cycle; counter <= WIDTH; -> CHECK.
- CHECK: busy=1. mul_lsb=1 -> ADD; mul_lsb=0 -> SHIFT.
- ADD: add_en=1, busy=1 for one cycle; -> SHIFT.
- SHIFT: shift_en=1, busy=1 for one cycle; counter <= counter-1.
  - If counter==1 on entry to SHIFT -> DONE.
  - Otherwise -> CHECK.
- DONE: done=1, counter=0. ack=1 -> IDLE. start in DONE is ignored; the request must be reissued from IDLE.
- abort:
  - Checked before all other transitions; abort=1 in any state -> IDLE on the next edge, counter <= 0.
  - abort in IDLE holds IDLE. abort and ack together in DONE -> IDLE.
- Pulse exclusivity: load, add_en and shift_en are mutually exclusive and never high in IDLE or DONE.
- done and busy are never high together.
- Latency, with start sampled at edge E and p = number of 1 bits in the multiplier:
  - LOAD in cycle 1 after E.
  - Iterations occupy 2*WIDTH + p cycles.
  - DONE entered in cycle 2 + 2*WIDTH + p.
  - Exactly p add_en pulses and exactly WIDTH shift_en pulses per operation.
- Counter arithmetic: unsigned CW bits. It is decremented only in SHIFT and never wraps, because exit occurs at 1. iter_left = counter.
- Reset asserted mid-operation: immediate return to the reset values above, with no completion of the current iteration.
- Illegal state encodings -> IDLE (default branch).

Test Plan:
- Reset mid-ADD (async, between edges) -> outputs 0 immediately. After release plus start=1, a full normal sequence runs from LOAD.
- WIDTH=4, multiplier 4'b1011, start 1 cycle:
  - load in cycle 1.
  - Pulses in order: ADD, SHIFT, ADD, SHIFT, SHIFT, ADD, SHIFT.
  - 3 add_en, 4 shift_en; done rises in cycle 13.
  - iter_left reads 4, 3, 2, 1 before each shift.
- WIDTH=4, multiplier 4'b0000:
  - 0 add_en, 4 shift_en; done in cycle 10.
  - With a datapath model, the product = 0.
- WIDTH=8, 13 x 11 with the datapath model:
  - p=3; done in cycle 21; product 143.
  - ack held low 5 cycles -> done stays high and busy=0.
  - ack=1 -> IDLE next cycle.
- abort asserted in the second CHECK -> IDLE next edge, busy=0, iter_left=0, no further pulses. A following start begins a fresh LOAD.
- start held high through DONE, with ack pulsed: no restart while in DONE. After ack, IDLE samples start=1 -> LOAD on the following edge.
